// File: rtl/vc4000_cart_loader.sv
// Cartridge loader: zero-fills the VC4000 ROM, then streams hps_io download bytes
// through a small write FIFO into the ROM port while holding the core in reset.
module vc4000_cart_loader #(
  parameter int         AW         = 15,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CART_INDEX = 8'd1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ready,
  output logic [AW:0]   cart_size,
  output logic          cart_loaded,
  output logic          hold_reset
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] WAIT_LVL = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_dl_prev;
  logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;
  logic          r_wait, w_wait_nxt;
  logic          r_mem_we, w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]    r_mem_din, w_mem_din_nxt;
  logic [AW:0]   r_cart_size, w_cart_size_nxt;
  logic          r_cart_loaded, w_cart_loaded_nxt;
  logic          r_hold_reset, w_hold_reset_nxt;
  logic          r_overflow, w_overflow_nxt;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [PW:0]   r_count, w_count_nxt;
  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [7:0]    r_fifo_data [FIFO_DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic          w_start;
  logic          w_addr_oob;
  logic [AW:0]   w_size_cand;

  assign w_accept    = r_mem_we & mem_ready;
  assign w_start     = ioctl_download & ~r_dl_prev & (ioctl_index == CART_INDEX);
  assign w_addr_oob  = (ioctl_addr >> AW) != 25'd0;
  assign w_size_cand = {1'b0, ioctl_addr[AW-1:0]} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt       = r_state;
    w_clr_addr_nxt    = r_clr_addr;
    w_wait_nxt        = r_wait;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_din_nxt     = r_mem_din;
    w_cart_size_nxt   = r_cart_size;
    w_cart_loaded_nxt = r_cart_loaded;
    w_hold_reset_nxt  = r_hold_reset;
    w_overflow_nxt    = r_overflow;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_count_nxt       = r_count;
    w_push            = 1'b0;
    w_pop             = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt       = S_CLEAR;
          w_clr_addr_nxt    = '0;
          w_cart_loaded_nxt = 1'b0;
          w_cart_size_nxt   = '0;
          w_hold_reset_nxt  = 1'b1;
          w_wait_nxt        = 1'b1;
          w_overflow_nxt    = 1'b0;
          w_wr_ptr_nxt      = '0;
          w_rd_ptr_nxt      = '0;
          w_count_nxt       = '0;
          w_mem_we_nxt      = 1'b1;
          w_mem_addr_nxt    = '0;
          w_mem_din_nxt     = 8'h00;
        end
      end

      // The zero write is kept posted on mem_* and only advanced once accepted.
      S_CLEAR: begin
        if (!ioctl_download) begin
          w_state_nxt       = S_IDLE;
          w_cart_loaded_nxt = 1'b0;
          w_hold_reset_nxt  = 1'b0;
          w_wait_nxt        = 1'b0;
          w_mem_we_nxt      = 1'b0;
        end else if (w_accept) begin
          if (r_clr_addr == {AW{1'b1}}) begin
            w_state_nxt  = S_LOAD;
            w_mem_we_nxt = 1'b0;
          end else begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
            w_mem_addr_nxt = r_clr_addr + 1'b1;
          end
        end
      end

      S_LOAD, S_DRAIN: begin
        if (r_state == S_LOAD && ioctl_wr) begin
          if (w_addr_oob || r_count == FULL_LVL) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_push = 1'b1;
            if (w_size_cand > r_cart_size) begin
              w_cart_size_nxt = w_size_cand;
            end
          end
        end

        w_pop = (r_count != '0) && (!r_mem_we || w_accept);
        if (w_pop) begin
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = r_fifo_addr[r_rd_ptr];
          w_mem_din_nxt  = r_fifo_data[r_rd_ptr];
          w_rd_ptr_nxt   = r_rd_ptr + 1'b1;
        end else if (w_accept) begin
          w_mem_we_nxt = 1'b0;
        end

        if (w_push) begin
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
          w_count_nxt = r_count - 1'b1;
        end

        // The spare slot absorbs the one strobe hps_io may send after wait rises.
        if (r_state == S_LOAD) begin
          w_wait_nxt = (w_count_nxt >= WAIT_LVL);
          if (!ioctl_download) begin
            w_state_nxt = S_DRAIN;
          end
        end else if (r_count == '0 && !r_mem_we) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_cart_loaded_nxt = ~r_overflow;
        w_hold_reset_nxt  = 1'b0;
        w_wait_nxt        = 1'b0;
        w_state_nxt       = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_dl_prev     <= 1'b0;
      r_clr_addr    <= '0;
      r_wait        <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= 8'h00;
      r_cart_size   <= '0;
      r_cart_loaded <= 1'b0;
      r_hold_reset  <= 1'b0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_dl_prev     <= ioctl_download;
      r_clr_addr    <= w_clr_addr_nxt;
      r_wait        <= w_wait_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_din     <= w_mem_din_nxt;
      r_cart_size   <= w_cart_size_nxt;
      r_cart_loaded <= w_cart_loaded_nxt;
      r_hold_reset  <= w_hold_reset_nxt;
      r_overflow    <= w_overflow_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ioctl_addr[AW-1:0];
      r_fifo_data[r_wr_ptr] <= ioctl_dout;
    end
  end

  assign ioctl_wait  = r_wait;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign cart_size   = r_cart_size;
  assign cart_loaded = r_cart_loaded;
  assign hold_reset  = r_hold_reset;

endmodule

// File: tb/tb_vc4000_cart_loader.sv
// Bench for vc4000_cart_loader: randomized downloads against a reference image
// (zero fill then bytes in address order) with a reduced ROM size.
module tb_vc4000_cart_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int ROM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_ready;
  logic [AW:0]   cart_size;
  logic          cart_loaded;
  logic          hold_reset;

  int checks = 0;
  int errors = 0;
  int readyMode = 0;
  int cyc = 0;
  int sent = 0;
  int waitViol = 0;
  bit monLoad = 1'b0;
  bit sawWait = 1'b0;
  int expSize = 0;
  int expLoaded = 0;
  logic [AW+7:0] wq[$];
  logic [7:0] img [ROM_N];

  always #5 clk = ~clk;

  vc4000_cart_loader #(
    .AW(AW),
    .FIFO_DEPTH(DEPTH),
    .CART_INDEX(8'd1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_ready(mem_ready),
    .cart_size(cart_size),
    .cart_loaded(cart_loaded),
    .hold_reset(hold_reset)
  );

  // Every completed ROM write, in the order the ROM accepted it.
  always @(posedge clk) begin
    if (reset_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      wq.push_back({mem_addr, mem_din});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge, then drive mem_ready and watch ioctl_wait.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (readyMode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 3 == 0);
      2:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
    if (ioctl_wait) sawWait = 1'b1;
    if (monLoad && ioctl_wait && (sent - (wq.size() - ROM_N)) < DEPTH - 1) waitViol++;
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input int nbytes, input int mode,
                               input bit randData, input bit addOob);
    int b;
    int bad;
    int total;
    logic [AW+7:0] expw;
    wq.delete();
    sent = 0;
    sawWait = 1'b0;
    waitViol = 0;
    readyMode = mode;
    for (int i = 0; i < nbytes; i++) img[i] = randData ? 8'($urandom) : 8'(i);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    total = nbytes + (addOob ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
      b = 0;
      while (ioctl_wait && b < 5000) begin
        tick();
        b++;
      end
      if (b >= 5000) begin
        checkOutput("wait_timeout", 32'(b), 32'(0));
        break;
      end
      ioctl_wr = 1'b1;
      ioctl_addr = (i < nbytes) ? 25'(i) : 25'(ROM_N);
      ioctl_dout = (i < nbytes) ? img[i] : 8'hA5;
      sent++;
      if (idx == 8'd1) monLoad = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    monLoad = 1'b0;
    tick();
    ioctl_download = 1'b0;
    if (idx == 8'd1) begin
      b = 0;
      tick();
      while (hold_reset !== 1'b0 && b < 5000) begin
        tick();
        b++;
      end
      checkOutput("done_timeout", 32'(b < 5000), 32'(1));
      expSize = nbytes;
      expLoaded = addOob ? 0 : 1;
    end
    repeat (3) tick();
    checkOutput("cart_size", 32'(cart_size), 32'(expSize));
    checkOutput("cart_loaded", 32'(cart_loaded), 32'(expLoaded));
    checkOutput("hold_reset_idle", 32'(hold_reset), 32'(0));
    checkOutput("wait_idle", 32'(ioctl_wait), 32'(0));
    checkOutput("wait_vs_fill", 32'(waitViol), 32'(0));
    if (idx == 8'd1) begin
      checkOutput("write_count", 32'(wq.size()), 32'(ROM_N + nbytes));
      bad = 0;
      foreach (wq[k]) begin
        if (k < ROM_N) expw = {AW'(k), 8'h00};
        else if (k - ROM_N < nbytes) expw = {AW'(k - ROM_N), img[k - ROM_N]};
        else expw = 'x;
        if (wq[k] !== expw) bad++;
      end
      checkOutput("rom_image", 32'(bad), 32'(0));
    end else begin
      checkOutput("foreign_writes", 32'(wq.size()), 32'(0));
      checkOutput("foreign_wait", 32'(sawWait), 32'(0));
    end
  endtask

  initial begin
    int b;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = 8'h00;
    mem_ready = 1'b1;
    repeat (2) tick();
    checkOutput("rst_wait", 32'(ioctl_wait), 32'(0));
    checkOutput("rst_we", 32'(mem_we), 32'(0));
    checkOutput("rst_addr", 32'(mem_addr), 32'(0));
    checkOutput("rst_din", 32'(mem_din), 32'(0));
    checkOutput("rst_size", 32'(cart_size), 32'(0));
    checkOutput("rst_loaded", 32'(cart_loaded), 32'(0));
    checkOutput("rst_hold", 32'(hold_reset), 32'(0));
    reset_n = 1'b1;
    tick();

    $display("[TB] ordered image, mem_ready=1");
    applyStimulus(8'd1, 512, 0, 1'b0, 1'b0);
    $display("[TB] random image, mem_ready 1-of-3");
    applyStimulus(8'd1, 300, 1, 1'b1, 1'b0);
    $display("[TB] foreign index download");
    applyStimulus(8'd2, 100, 0, 1'b1, 1'b0);
    $display("[TB] out-of-range byte appended");
    applyStimulus(8'd1, 256, 2, 1'b1, 1'b1);

    $display("[TB] abort during clear");
    wq.delete();
    readyMode = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    b = 0;
    tick();
    while (!(mem_we === 1'b1 && mem_addr == AW'(500)) && b < 3000) begin
      tick();
      b++;
    end
    checkOutput("abort_reach", 32'(b < 3000), 32'(1));
    checkOutput("abort_hold_before", 32'(hold_reset), 32'(1));
    ioctl_download = 1'b0;
    tick();
    expSize = 0;
    expLoaded = 0;
    checkOutput("abort_hold", 32'(hold_reset), 32'(0));
    checkOutput("abort_loaded", 32'(cart_loaded), 32'(0));
    checkOutput("abort_we", 32'(mem_we), 32'(0));
    checkOutput("abort_wait", 32'(ioctl_wait), 32'(0));
    tick();
    applyStimulus(8'd1, 200, 2, 1'b1, 1'b0);

    $display("[TB] reset mid-load with a full write buffer");
    readyMode = 0;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    b = 0;
    while (ioctl_wait && b < 3000) begin
      tick();
      b++;
    end
    readyMode = 3;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'h30 + i);
      tick();
    end
    ioctl_wr = 1'b0;
    checkOutput("stall_wait", 32'(ioctl_wait), 32'(1));
    checkOutput("stall_we", 32'(mem_we), 32'(1));
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    checkOutput("arst_wait", 32'(ioctl_wait), 32'(0));
    checkOutput("arst_we", 32'(mem_we), 32'(0));
    checkOutput("arst_addr", 32'(mem_addr), 32'(0));
    checkOutput("arst_din", 32'(mem_din), 32'(0));
    checkOutput("arst_size", 32'(cart_size), 32'(0));
    checkOutput("arst_hold", 32'(hold_reset), 32'(0));
    expSize = 0;
    expLoaded = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(8'd1, ROM_N, 2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
